// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch sequencer between the instruction ROM and IF/ID.
// It owns the PC and drives the ROM chip-enable and address. Fetched words go
// into a small in-order queue, which is presented to decode with a
// valid/ready handshake. A flush (branch or exception redirect) empties the
// queue and reloads the PC.
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   rom_ce, rom_addr  - ROM fetch enable and byte address (rom_addr = pc)
//   rom_inst          - ROM data, combinational with rom_addr
//   flush, flush_pc   - redirect request and target (low two bits ignored)
//   if_valid, if_inst, if_pc, id_ready - head-of-queue handshake to decode
module inst_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h00000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {BOOT, FETCH, FULL} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             pc;
  logic [CW-1:0]                 count, count_nxt;
  logic [PW-1:0]                 rd_ptr, wr_ptr;
  logic [QDEPTH-1:0][DATA_W-1:0] q_inst;
  logic [QDEPTH-1:0][ADDR_W-1:0] q_pc;
  logic                          nonempty, deq, fire;

  assign nonempty = (count != '0);

  // rst gating keeps outputs quiet during reset even when the FSM was mid-run.
  assign if_valid = ~rst & ~flush & nonempty;
  assign deq      = if_valid & id_ready;
  // In FULL no fetch is issued even when a dequeue frees a slot; fetching
  // resumes in the FETCH cycle that follows.
  assign fire     = ~rst & (state == FETCH) & ~flush &
                    ((count < CW'(QDEPTH)) | deq);

  assign rom_ce   = fire;
  assign rom_addr = pc;
  assign if_inst  = (~rst & nonempty) ? q_inst[rd_ptr] : '0;
  assign if_pc    = (~rst & nonempty) ? q_pc[rd_ptr]   : '0;

  assign count_nxt = count + CW'(fire) - CW'(deq);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      state  <= BOOT;
    end else if (flush) begin
      pc     <= flush_pc & ~ADDR_W'(3);
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      state  <= FETCH;
    end else begin
      count <= count_nxt;
      if (deq)  rd_ptr <= rd_ptr + PW'(1);
      if (fire) begin
        wr_ptr <= wr_ptr + PW'(1);
        pc     <= pc + ADDR_W'(4);
      end
      case (state)
        BOOT:    state <= FETCH;
        FETCH:   if (count_nxt == CW'(QDEPTH) && !deq) state <= FULL;
        FULL:    if (deq) state <= FETCH;
        default: state <= BOOT;
      endcase
    end
  end

  // Queue storage needs no reset; outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (fire) begin
      q_inst[wr_ptr] <= rom_inst;
      q_pc[wr_ptr]   <= pc;
    end
  end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;
  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst, flush, id_ready;
  logic [31:0] flush_pc;
  logic        rom_ce, if_valid;
  logic [31:0] rom_addr, rom_inst, if_inst, if_pc;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign rom_inst = rom(rom_addr);

  inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .QDEPTH(QD), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst), .flush(flush), .flush_pc(flush_pc),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready)
  );

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: 0=BOOT 1=FETCH 2=FULL
  logic [31:0] m_pc;
  ent_t        m_q[$];
  int          m_st;

  // Drive one cycle of inputs, push what the outputs must be this cycle,
  // advance the model to the next edge.
  task automatic step(input logic r, input logic f, input logic [31:0] fpc,
                      input logic rdy, input bit push = 1'b1);
    exp_t e;
    logic deq, fire;
    rst = r; flush = f; flush_pc = fpc; id_ready = rdy;
    e.addr  = m_pc;
    e.valid = !r && !f && (m_q.size() > 0);
    deq     = e.valid && rdy;
    fire    = !r && (m_st == 1) && !f && ((m_q.size() < QD) || deq);
    e.ce    = fire;
    e.pc    = (!r && m_q.size() > 0) ? m_q[0].pc   : 32'h0;
    e.inst  = (!r && m_q.size() > 0) ? m_q[0].inst : 32'h0;
    if (push) sb.push_back(e);
    if (r) begin
      m_pc = 32'h0; m_q.delete(); m_st = 0;
    end else if (f) begin
      m_pc = fpc & 32'hFFFF_FFFC; m_q.delete(); m_st = 1;
    end else begin
      ent_t n;
      if (deq) void'(m_q.pop_front());
      if (fire) begin
        n.pc = m_pc; n.inst = rom(m_pc);
        m_q.push_back(n);
        m_pc = m_pc + 32'd4;
      end
      case (m_st)
        0: m_st = 1;
        1: if (m_q.size() == QD && !deq) m_st = 2;
        2: if (deq) m_st = 1;
        default: m_st = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rom_ce",   32'(rom_ce),   32'(e.ce));
      chk("rom_addr", rom_addr,      e.addr);
      chk("if_valid", 32'(if_valid), 32'(e.valid));
      chk("if_pc",    if_pc,         e.pc);
      chk("if_inst",  if_inst,       e.inst);
    end
  end

  initial begin
    m_pc = 32'h0; m_st = 0;
    // DUT state before the first edge is unknown: do not check it.
    step(1, 0, 0, 0, 1'b0);
    step(1, 0, 0, 0);
    // Streaming with decode always ready
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    // Stall from boot, one-cycle release, then continuous ready from full
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    // Fill the queue, then flush to a misaligned target
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0102, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    // PC wrap through the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    // Back-to-back flushes: only the last target is fetched
    step(0, 1, 32'h0000_0200, 1);
    step(0, 1, 32'h0000_0300, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    // Reset while the queue is non-empty and decode is ready
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    // Flush in the BOOT cycle
    step(1, 0, 0, 1);
    step(0, 1, 32'h0000_0040, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
